// File: rtl/afu_frm_rd_sched_if.sv
// rtl/afu_frm_rd_sched_if.sv - cache-line source stream from the frame read scheduler
interface afu_frm_rd_sched_if #(
  parameter int CL   = 512,
  parameter int N_CH = 4
);
  localparam int CH_W = $clog2(N_CH);

  logic [CL-1:0]   src_data;
  logic            src_valid;
  logic            src_ready;
  logic            src_sop;
  logic            src_eop;
  logic [CH_W-1:0] src_ch;

  modport master (output src_data, src_valid, src_sop, src_eop, src_ch, input src_ready);
  modport slave  (input src_data, src_valid, src_sop, src_eop, src_ch, output src_ready);
endinterface

// File: rtl/afu_frm_rd_sched.sv
// rtl/afu_frm_rd_sched.sv - round-robin AFU frame read scheduler over N_CH frame buffers
// Define AFU_FRM_RD_SCHED_STAT_EN to enable the per-channel completed-frame counters.
module afu_frm_rd_sched #(
  parameter int N_CH                = 4,
  parameter int CL                  = 512,
  parameter int w_NumOfST_in_AFUFrm = 16,
  parameter int LOG2_ST_PER_CL      = 5
) (
  input  logic                                clk,
  input  logic                                rst_sync,
  input  logic [N_CH-1:0]                     ch_rd_ready,
  input  logic [N_CH*w_NumOfST_in_AFUFrm-1:0] ch_sb_len,
  input  logic [N_CH*CL-1:0]                  ch_rd_data,
  output logic [N_CH-1:0]                     ch_rd_en,
  output logic [N_CH-1:0]                     ch_rd_finish,
  afu_frm_rd_sched_if.master                  src,
  output logic [N_CH*16-1:0]                  stat_frm_cnt
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int W     = w_NumOfST_in_AFUFrm;
  localparam int CNT_W = W - LOG2_ST_PER_CL + 1;

  typedef enum logic [1:0] {IDLE, LOAD, READ, FIN} state_t;

  state_t          state, state_nxt;
  logic [CH_W-1:0] grant, rr_ptr, pick;
  logic            pick_vld;
  logic [CNT_W-1:0] remaining, cl_cnt;
  logic            first_beat;
  logic            last_beat;
  logic            accept;
  logic [W-1:0]    sb_len;

  // The extra count bit absorbs the round-up when sb_len is all ones.
  assign sb_len    = ch_sb_len[int'(grant)*W +: W];
  assign cl_cnt    = CNT_W'(sb_len >> LOG2_ST_PER_CL) + CNT_W'(|sb_len[LOG2_ST_PER_CL-1:0]);
  assign last_beat = (remaining == CNT_W'(1));

  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!pick_vld && ch_rd_ready[(int'(rr_ptr) + i) % N_CH]) begin
        pick_vld = 1'b1;
        pick     = CH_W'((int'(rr_ptr) + i) % N_CH);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      remaining  <= '0;
      first_beat <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (pick_vld) grant <= pick;
        LOAD: begin
          remaining  <= cl_cnt;
          first_beat <= 1'b1;
        end
        READ: if (accept) begin
          remaining  <= remaining - CNT_W'(1);
          first_beat <= 1'b0;
        end
        FIN:  rr_ptr <= (int'(grant) == N_CH - 1) ? '0 : grant + 1'b1;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    src.src_valid = 1'b0;
    src.src_sop   = 1'b0;
    src.src_eop   = 1'b0;
    src.src_ch    = '0;
    src.src_data  = '0;
    ch_rd_en      = '0;
    ch_rd_finish  = '0;
    accept        = 1'b0;
    case (state)
      IDLE: if (pick_vld) state_nxt = LOAD;
      LOAD: state_nxt = (cl_cnt != '0) ? READ : FIN;
      READ: begin
        src.src_valid   = 1'b1;
        src.src_data    = ch_rd_data[int'(grant)*CL +: CL];
        src.src_ch      = grant;
        src.src_sop     = first_beat;
        src.src_eop     = last_beat;
        accept          = src.src_ready;
        ch_rd_en[grant] = src.src_ready;
        if (src.src_ready && last_beat) state_nxt = FIN;
      end
      FIN: begin
        ch_rd_finish[grant] = 1'b1;
        state_nxt           = IDLE;
      end
    endcase
    // Outputs are forced quiet while reset is held, even mid-frame.
    if (rst_sync) begin
      src.src_valid = 1'b0;
      src.src_sop   = 1'b0;
      src.src_eop   = 1'b0;
      src.src_ch    = '0;
      src.src_data  = '0;
      ch_rd_en      = '0;
      ch_rd_finish  = '0;
      accept        = 1'b0;
    end
  end

`ifdef AFU_FRM_RD_SCHED_STAT_EN
  logic [15:0] frm_cnt [N_CH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (rst_sync)             frm_cnt[i] <= '0;
      else if (ch_rd_finish[i]) frm_cnt[i] <= frm_cnt[i] + 16'd1;
    end
  end

  always_comb begin
    stat_frm_cnt = '0;
    for (int i = 0; i < N_CH; i++) stat_frm_cnt[i*16 +: 16] = frm_cnt[i];
  end
`else
  assign stat_frm_cnt = '0;
`endif
endmodule

// File: tb/tb_afu_frm_rd_sched.sv
// tb/tb_afu_frm_rd_sched.sv - self-checking bench for afu_frm_rd_sched
module tb_afu_frm_rd_sched;
  localparam int N_CH = 4;
  localparam int CL   = 512;
  localparam int W    = 16;

  logic                clk = 1'b0;
  logic                rst_sync;
  logic [N_CH-1:0]     ch_rd_ready;
  logic [N_CH*W-1:0]   ch_sb_len;
  logic [N_CH*CL-1:0]  ch_rd_data;
  logic [N_CH-1:0]     ch_rd_en;
  logic [N_CH-1:0]     ch_rd_finish;
  logic [N_CH*16-1:0]  stat_frm_cnt;

  afu_frm_rd_sched_if #(.CL(CL), .N_CH(N_CH)) src_if ();

  afu_frm_rd_sched #(.N_CH(N_CH), .CL(CL), .w_NumOfST_in_AFUFrm(W), .LOG2_ST_PER_CL(5)) dut (
    .clk(clk), .rst_sync(rst_sync), .ch_rd_ready(ch_rd_ready), .ch_sb_len(ch_sb_len),
    .ch_rd_data(ch_rd_data), .ch_rd_en(ch_rd_en), .ch_rd_finish(ch_rd_finish),
    .src(src_if), .stat_frm_cnt(stat_frm_cnt)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          rr_m;
  int          popcnt [N_CH];
  int          stat_m [N_CH];
  int          len_m  [N_CH];
  logic [31:0] salt   [N_CH];
  logic [N_CH-1:0] mask_m;
  int          g;

  task automatic chk(input string tag, input logic [CL-1:0] obs, input logic [CL-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CL-1:0] exp_data(input int c, input int n);
    logic [CL-1:0] d;
    for (int w = 0; w < CL/32; w++) d[w*32 +: 32] = {8'(c), 8'(w), 16'(n)} ^ salt[c];
    return d;
  endfunction

  function automatic int rr_pick(input logic [N_CH-1:0] m, input int p);
    for (int i = 0; i < N_CH; i++) if (m[(p + i) % N_CH]) return (p + i) % N_CH;
    return -1;
  endfunction

  task automatic drive_data();
    for (int c = 0; c < N_CH; c++) ch_rd_data[c*CL +: CL] = exp_data(c, popcnt[c]);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, src_if.src_valid, 0);
    chk({tag, "_sop_eop"}, {src_if.src_sop, src_if.src_eop}, 0);
    chk({tag, "_ch"}, src_if.src_ch, 0);
    chk({tag, "_rd_en"}, ch_rd_en, 0);
    chk({tag, "_finish"}, ch_rd_finish, 0);
  endtask

  task automatic chk_stat();
    for (int c = 0; c < N_CH; c++) begin
`ifdef AFU_FRM_RD_SCHED_STAT_EN
      chk($sformatf("stat%0d", c), stat_frm_cnt[c*16 +: 16], 16'(stat_m[c]));
`else
      chk($sformatf("stat%0d", c), stat_frm_cnt[c*16 +: 16], 0);
`endif
    end
  endtask

  task automatic do_reset();
    rst_sync = 1'b1; ch_rd_ready = '0; ch_sb_len = '0; src_if.src_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_quiet("rst");
    rst_sync = 1'b0;
    rr_m = 0;
    for (int c = 0; c < N_CH; c++) stat_m[c] = 0;
  endtask

  // One frame: mask_m/len_m hold the request; pct<0 alternates src_ready 1/0.
  task automatic run_frame(input int pct, output int gr);
    int n, k, cyc, eop_cyc;
    bit done, tog;
    gr = rr_pick(mask_m, rr_m);
    n = (len_m[gr] + 31) / 32;
    k = 0; cyc = 0; eop_cyc = -10; done = 0; tog = 1;
    ch_rd_ready = mask_m;
    for (int c = 0; c < N_CH; c++) ch_sb_len[c*W +: W] = W'(len_m[c]);
    while (!done && cyc < 100 + n * 40) begin
      @(negedge clk);
      drive_data();
      src_if.src_ready = (pct < 0) ? tog : ($urandom_range(99) < pct);
      tog = ~tog;
      #1;
      if (src_if.src_valid) begin
        chk("beat_in_range", k < n, 1);
        chk("src_ch", src_if.src_ch, gr);
        chk("src_data", src_if.src_data, exp_data(gr, popcnt[gr]));
        chk("src_sop", src_if.src_sop, k == 0);
        chk("src_eop", src_if.src_eop, k == n - 1);
        chk("rd_en", ch_rd_en, src_if.src_ready ? (N_CH'(1) << gr) : '0);
        if (src_if.src_ready) begin
          if (k == n - 1) eop_cyc = cyc;
          k++; popcnt[gr]++;
        end
        // Request lines are scrambled mid-frame; the scheduler must ignore them.
        if (k == 1) begin
          ch_rd_ready = N_CH'($urandom);
          ch_sb_len   = (N_CH*W)'({$urandom, $urandom});
        end
      end else begin
        chk("rd_en_idle", ch_rd_en, 0);
      end
      if (ch_rd_finish != '0) begin
        chk("finish_ch", ch_rd_finish, N_CH'(1) << gr);
        chk("beat_count", k, n);
        if (n > 0) chk("finish_after_eop", cyc, eop_cyc + 1);
        done = 1;
      end
      cyc++;
    end
    if (!done) chk("finish_timeout", 0, 1);
    rr_m = (gr + 1) % N_CH;
    stat_m[gr] = (stat_m[gr] + 1) % 65536;
    @(negedge clk);
    #1 chk_quiet("post_fin");
    ch_rd_ready = '0;
    chk_stat();
  endtask

  initial begin
    for (int c = 0; c < N_CH; c++) begin
      salt[c] = $urandom; popcnt[c] = 0; len_m[c] = 0;
    end
    src_if.src_ready = 1'b0;
    drive_data();
    do_reset();
    chk_stat();
    repeat (3) begin
      @(negedge clk); #1 chk_quiet("no_req");
    end

    // ch0, 64 STs -> 2 beats
    mask_m = 4'b0001; len_m[0] = 64;
    run_frame(100, g); chk("grant_a", g, 0);
    // ch1, 33 STs, alternating ready -> 2 beats
    mask_m = 4'b0010; len_m[1] = 33;
    run_frame(-1, g); chk("grant_b", g, 1);

    // all channels ready -> 0,1,2,3,0
    do_reset();
    mask_m = 4'b1111;
    for (int c = 0; c < N_CH; c++) len_m[c] = 32;
    for (int i = 0; i < 5; i++) begin
      run_frame(100, g); chk($sformatf("rr_order%0d", i), g, i % N_CH);
    end

    // zero-length frame on ch2, then rr must start at 3
    mask_m = 4'b0100; len_m[2] = 0;
    run_frame(100, g); chk("grant_zero", g, 2);
    mask_m = 4'b1111;
    run_frame(100, g); chk("rr_after_zero", g, 3);

    // reset on beat 3 of a 5-beat frame
    mask_m = 4'b0100; len_m[2] = 160;
    ch_rd_ready = mask_m; ch_sb_len[2*W +: W] = 16'd160;
    begin
      int k = 0, cyc = 0;
      bit hit = 0;
      while (!hit && cyc < 50) begin
        @(negedge clk); drive_data(); src_if.src_ready = 1'b1; #1;
        if (src_if.src_valid && k == 2) begin
          rst_sync = 1'b1; hit = 1;
          #1 chk_quiet("rst_mid_same");
        end else if (src_if.src_valid) begin
          k++; popcnt[2]++;
        end
        cyc++;
      end
      chk("rst_mid_reached", hit, 1);
    end
    @(negedge clk); #1 chk_quiet("rst_mid_next");
    rst_sync = 1'b0; ch_rd_ready = '0; src_if.src_ready = 1'b0;
    rr_m = 0;
    for (int c = 0; c < N_CH; c++) stat_m[c] = 0;
    @(negedge clk); #1 chk_quiet("rst_mid_release");
    mask_m = 4'b1001; len_m[0] = 32; len_m[3] = 32;
    run_frame(100, g); chk("grant_after_rst", g, 0);

    // three frames on ch1 for the counters
    do_reset();
    mask_m = 4'b0010; len_m[1] = 40;
    repeat (3) run_frame(70, g);

    // largest frame length
    mask_m = 4'b0001; len_m[0] = 65535;
    run_frame(100, g); chk("grant_max", g, 0);

    // randomized frames
    for (int i = 0; i < 40; i++) begin
      mask_m = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      for (int c = 0; c < N_CH; c++)
        len_m[c] = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(400));
      run_frame(int'($urandom_range(40, 100)), g);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
